wb_write_queue: RTL and testbench

Writeback-side writer for the scalar register file: accepts 128-bit results from the ALU and memory-load paths, buffers them in a small in-order FIFO, and issues at most one register write per cycle on the register file's write port (`regWrEnScalar`, `regToWrite`, `dataIn`). It also exports a per-register pending mask so decode can stall on read-after-write hazards against writes that are queued but not yet committed. It sits between execute/memory and the register file.

---
 rtl/wb_write_queue.sv | 132 +++++++++++++
 tb/tb_wb_write_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// In-order writeback queue for the scalar register file: buffers ALU/load results
// and issues at most one registered write per cycle, exporting a pending-write mask.
module wb_write_queue #(
  parameter int regSize = 128,
  parameter int selBits = 2,
  parameter int depth   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      aluValid,
  input  logic [selBits-1:0]        aluReg,
  input  logic [regSize-1:0]        aluData,
  output logic                      aluReady,
  input  logic                      memValid,
  input  logic [selBits-1:0]        memReg,
  input  logic [regSize-1:0]        memData,
  output logic                      memReady,
  input  logic                      wbStall,
  output logic                      regWrEnScalar,
  output logic [selBits-1:0]        regToWrite,
  output logic [regSize-1:0]        dataIn,
  output logic [(1<<selBits)-1:0]   pendingMask,
  output logic [$clog2(depth):0]    count
);

  localparam int PW   = $clog2(depth);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << selBits;

  typedef struct packed {
    logic [selBits-1:0] rd;
    logic [regSize-1:0] data;
  } wq_entry_t;

  wq_entry_t              ent_q [depth];
  logic [depth-1:0]       vld_q, vld_d;
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   wr_en_q, wr_en_d;
  logic [selBits-1:0]     wr_reg_q, wr_reg_d;
  logic [regSize-1:0]     wr_data_q, wr_data_d;

  logic                   full, push, pop;
  wq_entry_t              push_ent;
  logic [depth-1:0][NREG-1:0] ent_hit;

  // Readiness comes from the pre-pop count, so a full queue never accepts
  // even in the cycle it drains one entry.
  assign full     = (count_q == CW'(depth));
  assign memReady = !full;
  assign aluReady = !full && !memValid;
  assign push     = (memValid && memReady) || (aluValid && aluReady);
  assign pop      = (count_q != '0) && !wbStall;

  always_comb begin
    push_ent = '0;
    if (memValid) begin
      push_ent.rd   = memReg;
      push_ent.data = memData;
    end else begin
      push_ent.rd   = aluReg;
      push_ent.data = aluData;
    end
  end

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    vld_d     = vld_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_en_d       = 1'b1;
      wr_reg_d      = ent_q[head_q].rd;
      wr_data_d     = ent_q[head_q].data;
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    if (push) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      vld_q     <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      vld_q     <= vld_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by vld_q.
  always_ff @(posedge clk) begin
    if (push) ent_q[tail_q] <= push_ent;
  end

  for (genvar g = 0; g < depth; g++) begin : g_hit
    assign ent_hit[g] = vld_q[g] ? (NREG'(1) << ent_q[g].rd) : '0;
  end

  always_comb begin
    pendingMask = '0;
    for (int i = 0; i < depth; i++) pendingMask = pendingMask | ent_hit[i];
    if (wr_en_q) pendingMask = pendingMask | (NREG'(1) << wr_reg_q);
  end

  assign regWrEnScalar = wr_en_q;
  assign regToWrite    = wr_reg_q;
  assign dataIn        = wr_data_q;
  assign count         = count_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: reset, single write, priority, fill/full,
// same-register ordering, push+pop at count 2 and a 10-entry wrap-around stream.
module tb_wb_write_queue;

  logic         clk = 1'b0;
  logic         reset;
  logic         aluValid, memValid, wbStall;
  logic [1:0]   aluReg, memReg;
  logic [127:0] aluData, memData;
  logic         aluReady, memReady, regWrEnScalar;
  logic [1:0]   regToWrite;
  logic [127:0] dataIn;
  logic [3:0]   pendingMask;
  logic [2:0]   count;

  int total  = 0;
  int passed = 0;

  wb_write_queue #(.regSize(128), .selBits(2), .depth(4)) dut (
    .clk(clk), .reset(reset),
    .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData), .aluReady(aluReady),
    .memValid(memValid), .memReg(memReg), .memData(memData), .memReady(memReady),
    .wbStall(wbStall),
    .regWrEnScalar(regWrEnScalar), .regToWrite(regToWrite), .dataIn(dataIn),
    .pendingMask(pendingMask), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aluValid = 1'b0; memValid = 1'b0; wbStall = 1'b0;
    aluReg = '0; memReg = '0; aluData = '0; memData = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #12;
    total++; if (count !== 3'd0) $display("FAIL rst_count got %0d exp 0", count); else passed++;
    total++; if (regWrEnScalar !== 1'b0) $display("FAIL rst_wren got %b exp 0", regWrEnScalar); else passed++;
    total++; if (dataIn !== 128'h0) $display("FAIL rst_data got %h exp 0", dataIn); else passed++;
    reset = 1'b0;
    tick();
    total++; if ({aluReady, memReady} !== 2'b11) $display("FAIL rst_ready got %b exp 11", {aluReady, memReady}); else passed++;
    // three entries queued behind a stall, then reset mid-cycle
    wbStall = 1'b1; aluValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      aluReg = 2'(i); aluData = 128'(i + 7);
      tick();
    end
    aluValid = 1'b0;
    total++; if (count !== 3'd3) $display("FAIL rst_pre_count got %0d exp 3", count); else passed++;
    total++; if (pendingMask !== 4'b0111) $display("FAIL rst_pre_mask got %b exp 0111", pendingMask); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (count !== 3'd0) $display("FAIL rst_mid_count got %0d exp 0", count); else passed++;
    total++; if (pendingMask !== 4'b0000) $display("FAIL rst_mid_mask got %b exp 0000", pendingMask); else passed++;
    total++; if (regWrEnScalar !== 1'b0) $display("FAIL rst_mid_wren got %b exp 0", regWrEnScalar); else passed++;
    tick();
    reset = 1'b0; wbStall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (regWrEnScalar !== 1'b0) $display("FAIL rst_post_wren cyc %0d got %b exp 0", i, regWrEnScalar); else passed++;
    end
  endtask

  task automatic test_single();
    idle_inputs();
    aluValid = 1'b1; aluReg = 2'd2; aluData = {16{8'hA5}};
    #1;
    total++; if (aluReady !== 1'b1) $display("FAIL single_ready got %b exp 1", aluReady); else passed++;
    tick();
    aluValid = 1'b0;
    total++; if (count !== 3'd1) $display("FAIL single_count got %0d exp 1", count); else passed++;
    total++; if (pendingMask !== 4'b0100) $display("FAIL single_mask_q got %b exp 0100", pendingMask); else passed++;
    total++; if (regWrEnScalar !== 1'b0) $display("FAIL single_wren_early got %b exp 0", regWrEnScalar); else passed++;
    tick();
    total++; if (regWrEnScalar !== 1'b1) $display("FAIL single_wren got %b exp 1", regWrEnScalar); else passed++;
    total++; if (regToWrite !== 2'd2) $display("FAIL single_reg got %0d exp 2", regToWrite); else passed++;
    total++; if (dataIn !== {16{8'hA5}}) $display("FAIL single_data got %h exp a5..a5", dataIn); else passed++;
    total++; if (pendingMask !== 4'b0100) $display("FAIL single_mask_wr got %b exp 0100", pendingMask); else passed++;
    tick();
    total++; if (regWrEnScalar !== 1'b0) $display("FAIL single_wren_off got %b exp 0", regWrEnScalar); else passed++;
    total++; if (pendingMask !== 4'b0000) $display("FAIL single_mask_off got %b exp 0000", pendingMask); else passed++;
    total++; if (dataIn !== {16{8'hA5}}) $display("FAIL single_data_hold got %h exp a5..a5", dataIn); else passed++;
  endtask

  task automatic test_priority();
    idle_inputs();
    memValid = 1'b1; memReg = 2'd1; memData = 128'h11;
    aluValid = 1'b1; aluReg = 2'd3; aluData = 128'h33;
    #1;
    total++; if ({aluReady, memReady} !== 2'b01) $display("FAIL prio_ready got %b exp 01", {aluReady, memReady}); else passed++;
    tick();
    memValid = 1'b0;
    #1;
    total++; if (aluReady !== 1'b1) $display("FAIL prio_alu_ready got %b exp 1", aluReady); else passed++;
    tick();
    aluValid = 1'b0;
    total++; if ({regWrEnScalar, regToWrite} !== 3'b1_01) $display("FAIL prio_wr1 got %b exp 101", {regWrEnScalar, regToWrite}); else passed++;
    total++; if (dataIn !== 128'h11) $display("FAIL prio_data1 got %h exp 11", dataIn); else passed++;
    tick();
    total++; if ({regWrEnScalar, regToWrite} !== 3'b1_11) $display("FAIL prio_wr2 got %b exp 111", {regWrEnScalar, regToWrite}); else passed++;
    total++; if (dataIn !== 128'h33) $display("FAIL prio_data2 got %h exp 33", dataIn); else passed++;
    tick();
    total++; if (regWrEnScalar !== 1'b0) $display("FAIL prio_idle got %b exp 0", regWrEnScalar); else passed++;
  endtask

  task automatic test_fill();
    logic [1:0] exp_reg [5];
    logic [127:0] exp_dat [5];
    exp_reg = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_dat = '{128'h100, 128'h101, 128'h102, 128'h103, 128'h200};
    idle_inputs();
    wbStall = 1'b1; aluValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aluReg = exp_reg[i]; aluData = exp_dat[i];
      tick();
    end
    aluReg = exp_reg[4]; aluData = exp_dat[4];
    #1;
    total++; if (count !== 3'd4) $display("FAIL fill_count got %0d exp 4", count); else passed++;
    total++; if ({aluReady, memReady} !== 2'b00) $display("FAIL fill_ready got %b exp 00", {aluReady, memReady}); else passed++;
    total++; if (pendingMask !== 4'b1111) $display("FAIL fill_mask got %b exp 1111", pendingMask); else passed++;
    tick();
    total++; if ({count, regWrEnScalar} !== 4'b100_0) $display("FAIL fill_held got %b exp 1000", {count, regWrEnScalar}); else passed++;
    wbStall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) aluValid = 1'b0;
      total++;
      if ({regWrEnScalar, regToWrite} !== {1'b1, exp_reg[i]} || dataIn !== exp_dat[i])
        $display("FAIL fill_drain_%0d got en=%b reg=%0d data=%h exp en=1 reg=%0d data=%h",
                 i, regWrEnScalar, regToWrite, dataIn, exp_reg[i], exp_dat[i]);
      else passed++;
      if (i == 0) begin
        total++; if (count !== 3'd3) $display("FAIL fill_nopush_on_full got %0d exp 3", count); else passed++;
      end
    end
    tick();
    total++; if ({count, regWrEnScalar} !== 4'b000_0) $display("FAIL fill_empty got %b exp 0000", {count, regWrEnScalar}); else passed++;
  endtask

  task automatic test_same_reg();
    idle_inputs();
    aluValid = 1'b1; aluReg = 2'd1; aluData = 128'h1;
    tick();
    aluData = 128'h2;
    tick();
    aluValid = 1'b0;
    total++; if ({regWrEnScalar, regToWrite, dataIn} !== {1'b1, 2'd1, 128'h1}) $display("FAIL same_wr1 got en=%b reg=%0d data=%h exp 1/1/1", regWrEnScalar, regToWrite, dataIn); else passed++;
    total++; if (pendingMask !== 4'b0010) $display("FAIL same_mask1 got %b exp 0010", pendingMask); else passed++;
    tick();
    total++; if ({regWrEnScalar, regToWrite, dataIn} !== {1'b1, 2'd1, 128'h2}) $display("FAIL same_wr2 got en=%b reg=%0d data=%h exp 1/1/2", regWrEnScalar, regToWrite, dataIn); else passed++;
    total++; if (pendingMask !== 4'b0010) $display("FAIL same_mask2 got %b exp 0010", pendingMask); else passed++;
    tick();
    total++; if (pendingMask !== 4'b0000) $display("FAIL same_mask_end got %b exp 0000", pendingMask); else passed++;
  endtask

  task automatic test_push_pop();
    idle_inputs();
    wbStall = 1'b1; aluValid = 1'b1;
    aluReg = 2'd0; aluData = 128'hA0; tick();
    aluReg = 2'd1; aluData = 128'hA1; tick();
    total++; if (count !== 3'd2) $display("FAIL pp_pre got %0d exp 2", count); else passed++;
    wbStall = 1'b0; aluReg = 2'd2; aluData = 128'hA2;
    tick();
    aluValid = 1'b0;
    total++; if (count !== 3'd2) $display("FAIL pp_count got %0d exp 2", count); else passed++;
    total++; if ({regWrEnScalar, regToWrite, dataIn} !== {1'b1, 2'd0, 128'hA0}) $display("FAIL pp_wr0 got en=%b reg=%0d data=%h", regWrEnScalar, regToWrite, dataIn); else passed++;
    total++; if (pendingMask !== 4'b0111) $display("FAIL pp_mask got %b exp 0111", pendingMask); else passed++;
    tick();
    total++; if ({regToWrite, dataIn} !== {2'd1, 128'hA1}) $display("FAIL pp_wr1 got reg=%0d data=%h", regToWrite, dataIn); else passed++;
    tick();
    total++; if ({regToWrite, dataIn} !== {2'd2, 128'hA2}) $display("FAIL pp_wr2 got reg=%0d data=%h", regToWrite, dataIn); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_d;
    idle_inputs();
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        aluValid = 1'b1; aluReg = 2'(i % 4); aluData = {96'h0, 32'hC0DE_0000 + 32'(i)};
      end else begin
        aluValid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 10) begin
        exp_d = {96'h0, 32'hC0DE_0000 + 32'(i - 1)};
        total++;
        if (regWrEnScalar !== 1'b1 || regToWrite !== 2'((i - 1) % 4) || dataIn !== exp_d)
          $display("FAIL b2b_%0d got en=%b reg=%0d data=%h exp en=1 reg=%0d data=%h",
                   i - 1, regWrEnScalar, regToWrite, dataIn, (i - 1) % 4, exp_d);
        else passed++;
      end
    end
    total++; if ({count, regWrEnScalar, pendingMask} !== 8'b000_0_0000) $display("FAIL b2b_end got %b exp 00000000", {count, regWrEnScalar, pendingMask}); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_priority();
    test_fill();
    test_same_reg();
    test_push_pop();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
